// File: rtl/mix_rx_fifo.sv
// UART 8N1 receiver with first-word-fall-through FIFO for the MIX console IN path.
// Build option: define MIX_RX_CHARCODE_EN to translate ASCII into MIX character codes on push.
module mix_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [7:0]            data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clear
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge
    // START  | timing to the middle of the start bit
    // DATA   | sampling eight data bits, LSB first
    // STOP   | timing to the middle of the stop bit
    // BREAK  | stop bit was low, waiting for the line to return high
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  TW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0]       TMR_FULL = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0]       TMR_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    state_t                r_state, w_state_next;
    logic                  r_rx_meta, r_rxs;
    logic [TW-1:0]         r_timer;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_push;
    logic [7:0]            r_push_data;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr, r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [7:0]            r_data_out;
    logic                  r_overrun, r_frame_err;

    logic                  w_tc;
    logic                  w_tmr_load;
    logic [TW-1:0]         w_tmr_val;
    logic                  w_shift_en, w_idx_clr, w_push_set, w_frame_evt;
    logic [7:0]            w_push_byte;
    logic                  w_pop, w_full, w_push_ok, w_ovr_evt;
    logic [DEPTH_LOG2-1:0] w_rd_next;
    logic [DEPTH_LOG2:0]   w_count_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_tc = (r_timer == TW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_rxs) w_state_next = S_START;
            S_START: if (w_tc) w_state_next = r_rxs ? S_IDLE : S_DATA;
            S_DATA:  if (w_tc && r_bit_idx == 3'd7) w_state_next = S_STOP;
            S_STOP:  if (w_tc) w_state_next = r_rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rxs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_val   = TMR_FULL;
        w_shift_en  = 1'b0;
        w_idx_clr   = 1'b0;
        w_push_set  = 1'b0;
        w_frame_evt = 1'b0;
        case (r_state)
            S_IDLE: if (!r_rxs) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_HALF;
            end
            S_START: if (w_tc && !r_rxs) begin
                w_tmr_load = 1'b1;
                w_idx_clr  = 1'b1;
            end
            S_DATA: if (w_tc) begin
                w_tmr_load = 1'b1;
                w_shift_en = 1'b1;
            end
            S_STOP: if (w_tc) begin
                w_push_set  = r_rxs;
                w_frame_evt = !r_rxs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_tmr_load)          r_timer <= w_tmr_val;
            else if (r_timer != '0)  r_timer <= r_timer - TW'(1);
            if (w_idx_clr)           r_bit_idx <= '0;
            else if (w_shift_en)     r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift_en)          r_shift <= {r_rxs, r_shift[7:1]};
        end
    end

`ifdef MIX_RX_CHARCODE_EN
    function automatic logic [7:0] f_charcode(input logic [7:0] c);
        logic [7:0] u;
        logic [7:0] r;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        r = 8'd0;
        if (u >= 8'h41 && u <= 8'h49)      r = u - 8'h40;
        else if (u >= 8'h4A && u <= 8'h52) r = u - 8'h3F;
        else if (u >= 8'h53 && u <= 8'h5A) r = u - 8'h3D;
        else if (u >= 8'h30 && u <= 8'h39) r = u - 8'h12;
        else begin
            case (u)
                8'h2E: r = 8'd40;
                8'h2C: r = 8'd41;
                8'h28: r = 8'd42;
                8'h29: r = 8'd43;
                8'h2B: r = 8'd44;
                8'h2D: r = 8'd45;
                8'h2A: r = 8'd46;
                8'h2F: r = 8'd47;
                8'h3D: r = 8'd48;
                8'h24: r = 8'd49;
                8'h3C: r = 8'd50;
                8'h3E: r = 8'd51;
                8'h40: r = 8'd52;
                8'h3B: r = 8'd53;
                8'h3A: r = 8'd54;
                8'h27: r = 8'd55;
                default: r = 8'd0;
            endcase
        end
        return r;
    endfunction

    assign w_push_byte = f_charcode(r_shift);
`else
    assign w_push_byte = r_shift;
`endif

    // Push is registered so the FIFO sees it one cycle after the stop-bit sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= w_push_set;
            if (w_push_set) r_push_data <= w_push_byte;
        end
    end

    assign w_pop     = ready && (r_count != '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_push_ok = r_push && (!w_full || w_pop);
    assign w_ovr_evt = r_push && w_full && !w_pop;
    assign w_rd_next = r_rd_ptr + DEPTH_LOG2'(w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop)      w_count_next = r_count + (DEPTH_LOG2 + 1)'(1);
        else if (!w_push_ok && w_pop) w_count_next = r_count - (DEPTH_LOG2 + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_push_data;
    end

    // Head register keeps data_out glitch-free and holds the last value when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_count_next != '0) begin
                if (w_push_ok && w_rd_next == r_wr_ptr) r_data_out <= r_push_data;
                else                                     r_data_out <= r_mem[w_rd_next];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_ovr_evt   || (r_overrun   && !clear);
            r_frame_err <= w_frame_evt || (r_frame_err && !clear);
        end
    end

    assign data_out  = r_data_out;
    assign valid     = (r_count != '0);
    assign count     = r_count;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mix_rx_fifo.sv
// Scoreboard bench for mix_rx_fifo: stimulus queues expected characters, a monitor checks each pop.
module tb_mix_rx_fifo;
    localparam int CPB = 8;
    localparam int DL  = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          rx    = 1'b1;
    logic          ready = 1'b0;
    logic          clear = 1'b0;
    logic [7:0]    data_out;
    logic          valid;
    logic [DL:0]   count;
    logic          overrun;
    logic          frame_err;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [7:0]    exp_q[$];

    mix_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clear     (clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ecode(input logic [7:0] c);
`ifdef MIX_RX_CHARCODE_EN
        case (c)
            8'h41:   return 8'd1;
            8'h42:   return 8'd2;
            8'h43:   return 8'd3;
            8'h44:   return 8'd4;
            8'h45:   return 8'd5;
            8'h46:   return 8'd6;
            8'h47:   return 8'd7;
            8'h48:   return 8'd8;
            8'h5A:   return 8'd29;
            8'h30:   return 8'd30;
            default: return 8'd0;
        endcase
`else
        return c;
`endif
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    // One 8N1 frame, 80 cycles; the DUT push lands on the last edge of the loop.
    task automatic send(input logic [7:0] b, input logic stop_bit, input bit pop_at_push);
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB)           rx = 1'b0;
            else if (i < 9 * CPB)  rx = b[(i - CPB) / CPB];
            else                   rx = stop_bit;
            if (pop_at_push && i == 10 * CPB - 1) ready = 1'b1;
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        rx    = 1'b1;
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got %0d expected no character", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", int'(data_out), int'(e));
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] chars [5];
        chars[0] = 8'h42; chars[1] = 8'h43; chars[2] = 8'h44;
        chars[3] = 8'h45; chars[4] = 8'h46;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        reset = 1'b1;
        cycles(2);

        // Back-to-back frames then single pops
        exp_q.push_back(ecode(8'h41));
        exp_q.push_back(ecode(8'h5A));
        send(8'h41, 1'b1, 1'b0);
        send(8'h5A, 1'b1, 1'b0);
        chk("b2b_count2", int'(count), 2);
        pop1();
        chk("b2b_count1", int'(count), 1);
        pop1();
        chk("b2b_count0", int'(count), 0);
        chk("b2b_overrun", int'(overrun), 0);
        chk("b2b_frame_err", int'(frame_err), 0);

        // One-cycle glitch in IDLE
        rx = 1'b0;
        cycles(1);
        rx = 1'b1;
        cycles(20);
        chk("glitch_count", int'(count), 0);
        chk("glitch_valid", int'(valid), 0);
        chk("glitch_frame_err", int'(frame_err), 0);

        // Framing error followed by a held-low line
        send(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        cycles(40);
        rx = 1'b1;
        cycles(10);
        chk("ferr_flag", int'(frame_err), 1);
        chk("ferr_count", int'(count), 0);
        chk("ferr_overrun", int'(overrun), 0);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("ferr_cleared", int'(frame_err), 0);

        // Overrun on a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(ecode(chars[i]));
            send(chars[i], 1'b1, 1'b0);
        end
        chk("ovr_count", int'(count), 4);
        chk("ovr_flag", int'(overrun), 1);
        pop1();
        chk("ovr_count_after_pop", int'(count), 3);
        exp_q.push_back(ecode(8'h47));
        send(8'h47, 1'b1, 1'b0);
        chk("ovr_refill_count", int'(count), 4);

        // Push and pop together while full
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);
        exp_q.push_back(ecode(8'h48));
        send(8'h48, 1'b1, 1'b1);
        chk("full_pp_count", int'(count), 4);
        chk("full_pp_overrun", int'(overrun), 0);
        ready = 1'b1;
        cycles(4);
        ready = 1'b0;
        chk("drain_count", int'(count), 0);
        chk("drain_valid", int'(valid), 0);

        // Reset in the middle of DATA with characters buffered
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ecode(chars[i]));
            send(chars[i], 1'b1, 1'b0);
        end
        chk("pre_rst_count", int'(count), 3);
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b1;
        cycles(5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_data_out", int'(data_out), 0);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_count", int'(count), 0);
        exp_q.delete();
        cycles(3);
        reset = 1'b1;
        cycles(3);
        exp_q.push_back(ecode(8'h30));
        send(8'h30, 1'b1, 1'b0);
        chk("post_rst_count", int'(count), 1);
        pop1();
        chk("post_rst_count0", int'(count), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mix_rx_fifo.md
Name: mix_rx_fifo

Overview:
- UART receive front end for the MIX console input path.
- Deserialises the rx pin (8N1) and buffers received characters in a small FIFO.
- Presents them first-word-fall-through to the IN unit, which packs characters into 30-bit MIX words and stores them to memory.
- Decouples serial arrival timing from instruction execution so characters arriving while IN is not yet issued are not lost.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 baud); minimum 4.
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  FIFO head character, valid only while valid=1.
- valid  output  1  FIFO not empty.
- ready  input  1  consumer pop; head removed on a cycle where valid & ready.
- count  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- overrun  output  1  sticky: a complete character was dropped because the FIFO was full.
- frame_err  output  1  sticky: a character was received with its stop bit low.
- clear  input  1  synchronous pulse that clears overrun and frame_err.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE, FIFO emptied.
  - data_out=0, valid=0, count=0, overrun=0, frame_err=0.
  - Synchroniser flops set to 1 (idle line).
  - A reset mid-frame discards the partial character.
- rx passes through a 2-flop synchroniser; all sampling uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rxs=0, load the bit timer with CLKS_PER_BIT/2 (integer division) and go to START.
- START: when the timer expires (mid start bit):
  - rxs=0: reload the timer with CLKS_PER_BIT, bit index=0, go to DATA.
  - rxs=1 (glitch): return to IDLE, no flag set.
- DATA: at each timer expiry, shift rxs into the shift register LSB first and reload the timer. After the 8th bit, go to STOP.
- STOP: at timer expiry:
  - rxs=1: push the byte and go to IDLE.
  - rxs=0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from generating repeated characters.
- Latency: the push is issued one cycle after the stop-bit centre sample. valid rises on the following cycle (registered FIFO, first-word-fall-through).
- FIFO:
  - Circular buffer; read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - count tracks occupancy separately; full means count = 2^DEPTH_LOG2.
  - Push while full, with no pop in the same cycle: byte dropped, overrun set, pointers and count unchanged.
  - Push and pop in the same cycle: both performed, count unchanged. When full, this push is accepted.
  - Pop while empty (ready=1, valid=0): ignored.
  - data_out holds the head entry; while empty it holds its last value.
- Sticky flags:
  - clear=1 zeroes both flags.
  - If clear and a new error event occur in the same cycle, the event wins and the flag stays set.
- Back-to-back frames: a start bit beginning immediately after the stop-bit sample is detected, because IDLE is entered at the stop-bit centre.

Optional Feature:
- Macro MIX_RX_CHARCODE_EN.
- Defined: the byte pushed into the FIFO is translated from ASCII to the MIX character code, zero-extended in data_out[7:0] (upper 2 bits 0). Mapping:
  - space→0; A-I→1-9; J-R→11-19; S-Z→22-29; lowercase maps as uppercase; 0-9→30-39.
  - . , ( ) + - * / = $ < > @ ; : ' → 40-55 in that order.
  - Any other byte → 0, and the character is still pushed.
- Not defined: raw 8-bit bytes are pushed unchanged. There is no translation logic.

Test Plan:
- CLKS_PER_BIT=8; send 0x41 then 0x5A back-to-back; pop each with ready=1. Required: data_out=0x41, then 0x5A; count 2→1→0; no flags. With MIX_RX_CHARCODE_EN defined: 1 then 29.
- 1-cycle-wide low glitch on rx while in IDLE. Required: FSM returns to IDLE, nothing pushed, count=0, frame_err=0.
- Send 0x55 with stop bit driven low, then rx held low for 40 cycles, then high. Required: frame_err=1, count=0, exactly zero characters pushed. Then pulse clear: frame_err=0.
- DEPTH_LOG2=2; send 5 characters with ready=0. Required: count=4, overrun=1, FIFO holds the first 4 in order. Pop one and send one more: count=4, new character sits at the tail.
- Full FIFO (count=4) with ready=1 held during the stop-bit push cycle. Required: count stays 4, overrun stays 0, order preserved across pointer wrap.
- Assert reset=0 mid-DATA with 3 characters buffered. Required: outputs zero immediately (asynchronous). After reset=1, a fresh character 0x30 is received correctly (MIX code 30 with the feature enabled).
